ecap5_dwbarb: RTL

ECAP5_DWBARB -- requirements
Module: ecap5_dwbarb

---
 rtl/ecap5_dwbarb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/ecap5_dwbarb.sv
// Two-master round-robin arbiter in front of a single pipelined Wishbone slave port.
// Ownership is held for a whole cycle (cyc) and hands over directly to the waiting master.
module ecap5_dwbarb #(
  parameter int unsigned FIRST_PRIORITY = 0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic [31:0] m0_wb_adr_i,
  input  logic [31:0] m0_wb_dat_i,
  output logic [31:0] m0_wb_dat_o,
  input  logic [3:0]  m0_wb_sel_i,
  input  logic        m0_wb_we_i,
  input  logic        m0_wb_stb_i,
  input  logic        m0_wb_cyc_i,
  output logic        m0_wb_ack_o,
  output logic        m0_wb_stall_o,

  input  logic [31:0] m1_wb_adr_i,
  input  logic [31:0] m1_wb_dat_i,
  output logic [31:0] m1_wb_dat_o,
  input  logic [3:0]  m1_wb_sel_i,
  input  logic        m1_wb_we_i,
  input  logic        m1_wb_stb_i,
  input  logic        m1_wb_cyc_i,
  output logic        m1_wb_ack_o,
  output logic        m1_wb_stall_o,

  output logic [31:0] s_wb_adr_o,
  output logic [31:0] s_wb_dat_o,
  input  logic [31:0] s_wb_dat_i,
  output logic [3:0]  s_wb_sel_o,
  output logic        s_wb_we_o,
  output logic        s_wb_stb_o,
  output logic        s_wb_cyc_o,
  input  logic        s_wb_ack_i,
  input  logic        s_wb_stall_i,

  output logic [1:0]  grant_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  // last_grant starts at the "other" master so FIRST_PRIORITY wins the first tie.
  localparam logic RESET_LAST = (FIRST_PRIORITY == 0) ? 1'b1 : 1'b0;

  state_t state, state_next;
  logic   last_grant;

  function automatic state_t arbitrate(input logic req0, input logic req1, input logic last);
    case ({req1, req0})
      2'b01:   return GRANT0;
      2'b10:   return GRANT1;
      2'b11:   return last ? GRANT0 : GRANT1;
      default: return IDLE;
    endcase
  endfunction

  // Next state depends only on cyc requests, state and last_grant; slave inputs never steer it.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    state_next = arbitrate(m0_wb_cyc_i, m1_wb_cyc_i, last_grant);
      GRANT0:  if (!m0_wb_cyc_i) state_next = arbitrate(1'b0, m1_wb_cyc_i, last_grant);
      GRANT1:  if (!m1_wb_cyc_i) state_next = arbitrate(m0_wb_cyc_i, 1'b0, last_grant);
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_i) begin
      state      <= IDLE;
      last_grant <= RESET_LAST;
    end else begin
      state <= state_next;
      if (state_next == GRANT0)      last_grant <= 1'b0;
      else if (state_next == GRANT1) last_grant <= 1'b1;
    end
  end

  assign grant_o = {state == GRANT1, state == GRANT0};

  // Read data is broadcast; only the granted master's ack qualifies it.
  assign m0_wb_dat_o = s_wb_dat_i;
  assign m1_wb_dat_o = s_wb_dat_i;

  always_comb begin
    s_wb_adr_o    = '0;
    s_wb_dat_o    = '0;
    s_wb_sel_o    = '0;
    s_wb_we_o     = 1'b0;
    s_wb_stb_o    = 1'b0;
    s_wb_cyc_o    = 1'b0;
    m0_wb_ack_o   = 1'b0;
    m0_wb_stall_o = 1'b1;
    m1_wb_ack_o   = 1'b0;
    m1_wb_stall_o = 1'b1;
    case (state)
      GRANT0: begin
        s_wb_adr_o    = m0_wb_adr_i;
        s_wb_dat_o    = m0_wb_dat_i;
        s_wb_sel_o    = m0_wb_sel_i;
        s_wb_we_o     = m0_wb_we_i;
        s_wb_stb_o    = m0_wb_stb_i;
        s_wb_cyc_o    = m0_wb_cyc_i;
        m0_wb_ack_o   = s_wb_ack_i;
        m0_wb_stall_o = s_wb_stall_i;
      end
      GRANT1: begin
        s_wb_adr_o    = m1_wb_adr_i;
        s_wb_dat_o    = m1_wb_dat_i;
        s_wb_sel_o    = m1_wb_sel_i;
        s_wb_we_o     = m1_wb_we_i;
        s_wb_stb_o    = m1_wb_stb_i;
        s_wb_cyc_o    = m1_wb_cyc_i;
        m1_wb_ack_o   = s_wb_ack_i;
        m1_wb_stall_o = s_wb_stall_i;
      end
      default: ;
    endcase
  end

endmodule
